// File: rtl/mod_reduce_pkg.sv
// Shared types and elaboration-time helpers for the sequential modular reducer.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package mod_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FOLD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // 2^e mod m by repeated doubling, so nothing ever exceeds 2*m.
    function automatic int pow2_mod(input int e, input int m);
        int r;
        r = 1 % m;
        for (int i = 0; i < e; i++) begin
            r = (r * 2) % m;
        end
        return r;
    endfunction

    // Entry i of the chunk weight table: 2^(k*i) mod m for real chunks, 0 for padding lanes.
    function automatic int weight_at(input int i, input int n, input int k, input int m);
        return (i < n) ? pow2_mod(k * i, m) : 0;
    endfunction

endpackage

// File: rtl/mod_fold_unit.sv
// Folds the bits above K back into the low K bits: lo + hi * F, with F = 2^K mod M.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the accumulator.
module mod_fold_unit #(
    parameter int K  = 9,
    parameter int AW = 22,
    parameter int F  = 9
) (
    input  logic [AW-1:0] i_acc,
    output logic [AW-1:0] o_acc
);

    // hi*F < 2^(AW-K) * 2^K, so the product never needs more than AW bits.
    assign o_acc = AW'(i_acc[K-1:0]) + AW'(i_acc[AW-1:K]) * AW'(F);

endmodule

// File: rtl/seq_mod_reduce.sv
// Computes out_r = in_x mod M by accumulating CPC weighted K-bit chunks per cycle, then folding.
// Latency: accept edge T -> out_valid from edge T+NC+1+folds (folds = 0 when acc already < 2^K).
// Backpressure: one operand in flight; in_ready only in IDLE, result held in DONE until out_ready.
module seq_mod_reduce
    import mod_reduce_pkg::*;
#(
    parameter int XW  = 500,
    parameter int M   = 503,
    parameter int CPC = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [XW-1:0]                         in_x,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [mod_reduce_pkg::clog2(M)-1:0]   out_r
);

    localparam int K  = clog2(M);
    localparam int N  = (XW + K - 1) / K;
    localparam int NC = (N + CPC - 1) / CPC;
    localparam int NW = NC * CPC;
    // Shift register is padded to whole ACCUM cycles so every lane always reads in range.
    localparam int SW = NW * K;
    localparam int F  = (1 << K) - M;
    localparam int AW = 2 * K + clog2(CPC) + 2;
    localparam int CW = (clog2(NC) > 0) ? clog2(NC) : 1;
    localparam int IW = (clog2(NW) > 0) ? clog2(NW) : 1;

    state_e          r_state;
    logic [SW-1:0]   r_sh;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;

    logic [K-1:0]    w_rom [NW];
    logic [IW-1:0]   w_idx;
    logic [AW-1:0]   w_lane_sum;
    logic [AW-1:0]   w_fold;

    // Weight ROM: constants fixed at elaboration, one per chunk position.
    for (genvar i = 0; i < NW; i++) begin : g_rom
        localparam logic [K-1:0] WV = K'(weight_at(i, N, K, M));
        assign w_rom[i] = WV;
    end

    mod_fold_unit #(
        .K  (K),
        .AW (AW),
        .F  (F)
    ) u_fold (
        .i_acc (r_acc),
        .o_acc (w_fold)
    );

    // Lane multiply-add tree: sum of chunk_j * W[c*CPC+j] over the CPC lanes.
    always_comb begin
        w_lane_sum = '0;
        w_idx      = '0;
        for (int j = 0; j < CPC; j++) begin
            w_idx      = IW'(int'(r_cnt) * CPC + j);
            w_lane_sum = w_lane_sum + AW'(r_sh[j*K +: K]) * AW'(w_rom[w_idx]);
        end
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sh      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_r     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_sh     <= SW'(in_x);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    // Folding the previous acc while adding new products keeps acc bounded.
                    r_acc <= w_fold + w_lane_sum;
                    r_sh  <= r_sh >> (CPC * K);
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NC - 1)) begin
                        r_state <= FOLD;
                    end
                end
                FOLD: begin
                    if (r_acc[AW-1:K] != '0) begin
                        r_acc <= w_fold;
                    end else begin
                        // acc < 2^K < 2M here, so one subtract is enough.
                        out_r     <= (r_acc[K-1:0] >= K'(M)) ? (r_acc[K-1:0] - K'(M)) : r_acc[K-1:0];
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mod_reduce.sv
// Self-checking bench for seq_mod_reduce: default config plus two extra parameter sets.
// Latency: checks the fixed accept-to-valid latency on directed operands.
// Backpressure: exercises held results, ignored inputs, mid-run reset and back-to-back traffic.
module tb_seq_mod_reduce;

    localparam int XW  = 500;
    localparam int M   = 503;
    localparam int CPC = 4;
    localparam int K   = 9;

    localparam int XW_B  = 100;
    localparam int M_B   = 1021;
    localparam int CPC_B = 3;
    localparam int K_B   = 10;

    localparam int XW_C  = 24;
    localparam int M_C   = 5;
    localparam int CPC_C = 8;
    localparam int K_C   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [XW-1:0]  in_x = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [K-1:0]   out_r;

    // Instance B: M=1021, CPC=3
    logic             b_rst = 1'b1;
    logic             b_in_valid = 1'b0;
    logic             b_in_ready;
    logic [XW_B-1:0]  b_in_x = '0;
    logic             b_out_valid;
    logic             b_out_ready = 1'b1;
    logic [K_B-1:0]   b_out_r;
    logic             b_done = 1'b0;

    // Instance C: M=5, CPC=8 (single ACCUM cycle)
    logic             c_rst = 1'b1;
    logic             c_in_valid = 1'b0;
    logic             c_in_ready;
    logic [XW_C-1:0]  c_in_x = '0;
    logic             c_out_valid;
    logic             c_out_ready = 1'b1;
    logic [K_C-1:0]   c_out_r;
    logic             c_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mod_reduce #(.XW(XW), .M(M), .CPC(CPC)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
    );

    seq_mod_reduce #(.XW(XW_B), .M(M_B), .CPC(CPC_B)) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_x      (b_in_x),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_r     (b_out_r)
    );

    seq_mod_reduce #(.XW(XW_C), .M(M_C), .CPC(CPC_C)) u_dut_c (
        .clk       (clk),
        .rst       (c_rst),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_x      (c_in_x),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_r     (c_out_r)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain binary long division, MSB first.
    function automatic logic [63:0] ref_mod(input logic [XW-1:0] x, input longint unsigned m);
        longint unsigned r;
        r = 0;
        for (int b = XW - 1; b >= 0; b--) begin
            r = (r * 2 + (x[b] ? 64'd1 : 64'd0)) % m;
        end
        return r;
    endfunction

    function automatic logic [XW-1:0] rand_x();
        logic [511:0] t;
        for (int w = 0; w < 16; w++) begin
            t[w*32 +: 32] = $urandom;
        end
        return t[XW-1:0];
    endfunction

    // Offer one operand, wait for its result, check it, and let the handshake complete.
    task automatic do_op(input logic [XW-1:0] x, input logic [63:0] exp, input bit chk_lat);
        int lat;
        @(negedge clk);
        check_eq("in_ready_idle", 64'(in_ready), 64'(1));
        in_x     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("in_ready_busy", 64'(in_ready), 64'(0));
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        check_eq("out_valid", 64'(out_valid), 64'(1));
        if (chk_lat) check_eq("latency", 64'(lat), 64'(15));
        check_eq("out_r", 64'(out_r), exp);
        @(posedge clk);
        #1;
        check_eq("out_valid_drop", 64'(out_valid), 64'(0));
    endtask

    // Main instance sequence
    initial begin : main_seq
        logic [XW-1:0]   x;
        logic [XW-1:0]   x2;
        logic [63:0]     exp;
        logic [XW-1:0]   dir_x [6];
        longint unsigned dir_r [6];
        int              lat;

        dir_x[0] = '0;
        dir_x[1] = XW'(502);
        dir_x[2] = XW'(503);
        dir_x[3] = '0; dir_x[3][9]  = 1'b1;
        dir_x[4] = '0; dir_x[4][18] = 1'b1;
        dir_x[5] = '0; dir_x[5][27] = 1'b1; dir_x[5][9] = 1'b1;
        dir_r = '{0, 502, 0, 9, 81, 235};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_r", 64'(out_r), 64'(0));

        // Directed operands with fixed latency
        for (int i = 0; i < 6; i++) begin
            do_op(dir_x[i], 64'(dir_r[i]), 1'b1);
        end

        // All ones
        x = '1;
        do_op(x, ref_mod(x, M), 1'b0);

        // Backpressure: result held, new operand ignored while busy
        x   = rand_x();
        exp = ref_mod(x, M);
        @(negedge clk);
        out_ready = 1'b0;
        in_x      = x;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        check_eq("bp_valid", 64'(out_valid), 64'(1));
        x2 = rand_x();
        @(negedge clk);
        in_x     = x2;
        in_valid = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", 64'(out_valid), 64'(1));
            check_eq("bp_hold_r", 64'(out_r), exp);
            check_eq("bp_hold_ready", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_valid", 64'(out_valid), 64'(0));
        check_eq("bp_release_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        check_eq("bp_next_accept", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        check_eq("bp_next_valid", 64'(out_valid), 64'(1));
        check_eq("bp_next_r", 64'(out_r), ref_mod(x2, M));
        @(posedge clk);
        #1;

        // Reset during ACCUM at c=5
        @(negedge clk);
        in_x     = rand_x();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("mid_rst_out_r", 64'(out_r), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        x = '0;
        x[18] = 1'b1;
        do_op(x, 64'd81, 1'b1);

        // Back-to-back with in_valid held high
        @(negedge clk);
        x        = rand_x();
        in_x     = x;
        in_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            check_eq("b2b_accept", 64'(in_ready), 64'(0));
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!out_valid && lat < 300);
            check_eq("b2b_r", 64'(out_r), ref_mod(x, M));
            @(posedge clk);
            #1;
            check_eq("b2b_idle", 64'(in_ready), 64'(1));
            x    = rand_x();
            in_x = x;
        end
        in_valid = 1'b0;

        // Random operands with varied bit density and magnitude
        for (int n = 0; n < 1500; n++) begin
            x = rand_x();
            if (n % 3 == 1) x = x & rand_x() & rand_x();
            if (n % 3 == 2) x = x >> $urandom_range(0, XW - 1);
            do_op(x, ref_mod(x, M), 1'b0);
        end

        for (int t = 0; t < 20000 && !(b_done && c_done); t++) begin
            @(posedge clk);
        end
        check_eq("aux_done", 64'(b_done && c_done), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Instance B: random operands, first one all ones
    initial begin : b_seq
        logic [XW-1:0] t;
        int            lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            t = rand_x();
            if (n % 2 == 1) t = t >> $urandom_range(0, XW_B - 1);
            t[XW-1:XW_B] = '0;
            if (n == 0) t[XW_B-1:0] = '1;
            @(negedge clk);
            check_eq("b_ready", 64'(b_in_ready), 64'(1));
            b_in_x     = t[XW_B-1:0];
            b_in_valid = 1'b1;
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!b_out_valid && lat < 300);
            check_eq("b_valid", 64'(b_out_valid), 64'(1));
            check_eq("b_r", 64'(b_out_r), ref_mod(t, M_B));
            @(posedge clk);
        end
        b_done = 1'b1;
    end

    // Instance C: random operands, first one all ones
    initial begin : c_seq
        logic [XW-1:0] t;
        int            lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        c_rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            t = rand_x();
            t[XW-1:XW_C] = '0;
            if (n == 0) t[XW_C-1:0] = '1;
            @(negedge clk);
            check_eq("c_ready", 64'(c_in_ready), 64'(1));
            c_in_x     = t[XW_C-1:0];
            c_in_valid = 1'b1;
            @(posedge clk);
            #1;
            c_in_valid = 1'b0;
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!c_out_valid && lat < 300);
            check_eq("c_valid", 64'(c_out_valid), 64'(1));
            check_eq("c_r", 64'(c_out_r), ref_mod(t, M_C));
            @(posedge clk);
        end
        c_done = 1'b1;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
